// File: rtl/decode_queue_pkg.sv
// rtl/decode_queue_pkg.sv - shared decode constants for the decode queue and pipeline
// Instruction numbers, class codes, exception codes and instruction field ranges.
package decode_queue_pkg;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 26;
  localparam int RS_HI   = 25;
  localparam int RS_LO   = 21;
  localparam int RT_HI   = 20;
  localparam int RT_LO   = 16;
  localparam int FUNC_HI = 5;
  localparam int FUNC_LO = 0;

  localparam int TYPE_NONE   = 0;
  localparam int TYPE_CALR   = 1;
  localparam int TYPE_CALI   = 2;
  localparam int TYPE_LD     = 3;
  localparam int TYPE_ST     = 4;
  localparam int TYPE_BRANCH = 5;
  localparam int TYPE_J      = 6;
  localparam int TYPE_JAL    = 7;
  localparam int TYPE_JR     = 8;
  localparam int TYPE_JALR   = 9;
  localparam int TYPE_CP0    = 10;

  localparam int EXC_NONE = 0;
  localparam int EXC_ADEL = 4;
  localparam int EXC_RI   = 10;

  // Numbers are grouped by class so irn_class can map them by range.
  localparam int IRN_NONE  = 0;
  localparam int IRN_ADD   = 1;
  localparam int IRN_ADDU  = 2;
  localparam int IRN_SUB   = 3;
  localparam int IRN_SUBU  = 4;
  localparam int IRN_AND   = 5;
  localparam int IRN_OR    = 6;
  localparam int IRN_XOR   = 7;
  localparam int IRN_NOR   = 8;
  localparam int IRN_SLT   = 9;
  localparam int IRN_SLTU  = 10;
  localparam int IRN_SLL   = 11;
  localparam int IRN_SRL   = 12;
  localparam int IRN_SRA   = 13;
  localparam int IRN_SLLV  = 14;
  localparam int IRN_SRLV  = 15;
  localparam int IRN_SRAV  = 16;
  localparam int IRN_MULT  = 17;
  localparam int IRN_MULTU = 18;
  localparam int IRN_DIV   = 19;
  localparam int IRN_DIVU  = 20;
  localparam int IRN_MTHI  = 21;
  localparam int IRN_MTLO  = 22;
  localparam int IRN_MFHI  = 23;
  localparam int IRN_MFLO  = 24;
  localparam int IRN_ADDI  = 25;
  localparam int IRN_ADDIU = 26;
  localparam int IRN_ANDI  = 27;
  localparam int IRN_ORI   = 28;
  localparam int IRN_XORI  = 29;
  localparam int IRN_LUI   = 30;
  localparam int IRN_SLTI  = 31;
  localparam int IRN_SLTIU = 32;
  localparam int IRN_LB    = 33;
  localparam int IRN_LBU   = 34;
  localparam int IRN_LH    = 35;
  localparam int IRN_LHU   = 36;
  localparam int IRN_LW    = 37;
  localparam int IRN_SB    = 38;
  localparam int IRN_SH    = 39;
  localparam int IRN_SW    = 40;
  localparam int IRN_BEQ   = 41;
  localparam int IRN_BNE   = 42;
  localparam int IRN_BLEZ  = 43;
  localparam int IRN_BGTZ  = 44;
  localparam int IRN_BLTZ  = 45;
  localparam int IRN_BGEZ  = 46;
  localparam int IRN_J     = 47;
  localparam int IRN_JAL   = 48;
  localparam int IRN_JR    = 49;
  localparam int IRN_JALR  = 50;
  localparam int IRN_ERET  = 51;
  localparam int IRN_MTC0  = 52;
  localparam int IRN_MFC0  = 53;

  function automatic int irn_class(input int irn);
    if (irn >= IRN_ADD && irn <= IRN_MFLO)        return TYPE_CALR;
    else if (irn >= IRN_ADDI && irn <= IRN_SLTIU) return TYPE_CALI;
    else if (irn >= IRN_LB && irn <= IRN_LW)      return TYPE_LD;
    else if (irn >= IRN_SB && irn <= IRN_SW)      return TYPE_ST;
    else if (irn >= IRN_BEQ && irn <= IRN_BGEZ)   return TYPE_BRANCH;
    else if (irn == IRN_J)                        return TYPE_J;
    else if (irn == IRN_JAL)                      return TYPE_JAL;
    else if (irn == IRN_JR)                       return TYPE_JR;
    else if (irn == IRN_JALR)                     return TYPE_JALR;
    else if (irn >= IRN_ERET && irn <= IRN_MFC0)  return TYPE_CP0;
    else                                          return TYPE_NONE;
  endfunction

endpackage

// File: rtl/instr_classifier.sv
// rtl/instr_classifier.sv - combinational MIPS-C instruction decode into number, class and exception
// CP0 instructions (eret/mtc0/mfc0) decode only when DECODE_CP0_INSTR_EN is defined.
module instr_classifier
  import decode_queue_pkg::*;
#(
  parameter int IRN_W  = 6,
  parameter int TYPE_W = 4
) (
  input  logic [31:0]       i_ir,
  input  logic [31:0]       i_pc,
  output logic [IRN_W-1:0]  o_irn,
  output logic [TYPE_W-1:0] o_type,
  output logic [4:0]        o_exc
);

  logic [5:0] w_op;
  logic [5:0] w_func;
  logic [4:0] w_rs;
  logic [4:0] w_rt;
  logic       w_unused_bits;
  int         w_irn;

  assign w_op          = i_ir[OP_HI:OP_LO];
  assign w_func        = i_ir[FUNC_HI:FUNC_LO];
  assign w_rs          = i_ir[RS_HI:RS_LO];
  assign w_rt          = i_ir[RT_HI:RT_LO];
  assign w_unused_bits = ^{i_pc[31:2], i_ir[15:6]};

  always_comb begin
    w_irn = IRN_NONE;
    case (w_op)
      6'b000000: begin
        case (w_func)
          6'b100000: w_irn = IRN_ADD;
          6'b100001: w_irn = IRN_ADDU;
          6'b100010: w_irn = IRN_SUB;
          6'b100011: w_irn = IRN_SUBU;
          6'b100100: w_irn = IRN_AND;
          6'b100101: w_irn = IRN_OR;
          6'b100110: w_irn = IRN_XOR;
          6'b100111: w_irn = IRN_NOR;
          6'b101010: w_irn = IRN_SLT;
          6'b101011: w_irn = IRN_SLTU;
          6'b000000: w_irn = IRN_SLL;
          6'b000010: w_irn = IRN_SRL;
          6'b000011: w_irn = IRN_SRA;
          6'b000100: w_irn = IRN_SLLV;
          6'b000110: w_irn = IRN_SRLV;
          6'b000111: w_irn = IRN_SRAV;
          6'b011000: w_irn = IRN_MULT;
          6'b011001: w_irn = IRN_MULTU;
          6'b011010: w_irn = IRN_DIV;
          6'b011011: w_irn = IRN_DIVU;
          6'b010001: w_irn = IRN_MTHI;
          6'b010011: w_irn = IRN_MTLO;
          6'b010000: w_irn = IRN_MFHI;
          6'b010010: w_irn = IRN_MFLO;
          6'b001000: w_irn = IRN_JR;
          6'b001001: w_irn = IRN_JALR;
          default:   w_irn = IRN_NONE;
        endcase
      end
      6'b000001: begin
        if (w_rt == 5'b00000)      w_irn = IRN_BLTZ;
        else if (w_rt == 5'b00001) w_irn = IRN_BGEZ;
        else                       w_irn = IRN_NONE;
      end
      6'b000010: w_irn = IRN_J;
      6'b000011: w_irn = IRN_JAL;
      6'b000100: w_irn = IRN_BEQ;
      6'b000101: w_irn = IRN_BNE;
      6'b000110: w_irn = IRN_BLEZ;
      6'b000111: w_irn = IRN_BGTZ;
      6'b001000: w_irn = IRN_ADDI;
      6'b001001: w_irn = IRN_ADDIU;
      6'b001010: w_irn = IRN_SLTI;
      6'b001011: w_irn = IRN_SLTIU;
      6'b001100: w_irn = IRN_ANDI;
      6'b001101: w_irn = IRN_ORI;
      6'b001110: w_irn = IRN_XORI;
      6'b001111: w_irn = IRN_LUI;
      6'b100000: w_irn = IRN_LB;
      6'b100001: w_irn = IRN_LH;
      6'b100011: w_irn = IRN_LW;
      6'b100100: w_irn = IRN_LBU;
      6'b100101: w_irn = IRN_LHU;
      6'b101000: w_irn = IRN_SB;
      6'b101001: w_irn = IRN_SH;
      6'b101011: w_irn = IRN_SW;
      6'b010000: begin
`ifdef DECODE_CP0_INSTR_EN
        if (w_rs == 5'b10000 && w_func == 6'b011000) w_irn = IRN_ERET;
        else if (w_rs == 5'b00100)                   w_irn = IRN_MTC0;
        else if (w_rs == 5'b00000)                   w_irn = IRN_MFC0;
        else                                         w_irn = IRN_NONE;
`else
        w_irn = IRN_NONE;
`endif
      end
      default: w_irn = IRN_NONE;
    endcase
  end

  assign o_irn  = IRN_W'(w_irn);
  assign o_type = TYPE_W'(irn_class(w_irn));

  // A misaligned fetch reports AdEL even when the word is also unrecognised.
  always_comb begin
    o_exc = 5'(EXC_NONE);
    if (i_pc[1:0] != 2'b00)    o_exc = 5'(EXC_ADEL);
    else if (w_irn == IRN_NONE) o_exc = 5'(EXC_RI);
  end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - decoded-instruction FIFO between fetch and the pipeline
// Decode happens at push time in instr_classifier; DECODE_CP0_INSTR_EN enables CP0 decode there.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int IRN_W  = 6,
  parameter int TYPE_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_ir,
  input  logic [31:0]            in_pc,
  input  logic                   in_bd,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_ir,
  output logic [31:0]            out_pc,
  output logic [IRN_W-1:0]       out_irn,
  output logic [TYPE_W-1:0]      out_type,
  output logic                   out_bd,
  output logic [4:0]             out_exc,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [31:0]       r_ir   [DEPTH];
  logic [31:0]       r_pc   [DEPTH];
  logic              r_bd   [DEPTH];
  logic [IRN_W-1:0]  r_irn  [DEPTH];
  logic [TYPE_W-1:0] r_type [DEPTH];
  logic [4:0]        r_exc  [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_cnt;

  logic [IRN_W-1:0]  w_irn;
  logic [TYPE_W-1:0] w_type;
  logic [4:0]        w_exc;
  logic              w_push;
  logic              w_pop;

  instr_classifier #(
    .IRN_W  (IRN_W),
    .TYPE_W (TYPE_W)
  ) u_classifier (
    .i_ir   (in_ir),
    .i_pc   (in_pc),
    .o_irn  (w_irn),
    .o_type (w_type),
    .o_exc  (w_exc)
  );

  assign in_ready  = (r_cnt != DEPTH_C);
  assign out_valid = (r_cnt != '0);
  assign count     = r_cnt;
  assign w_push    = in_valid && in_ready && !flush;
  assign w_pop     = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_ir[i]   <= '0;
        r_pc[i]   <= '0;
        r_bd[i]   <= 1'b0;
        r_irn[i]  <= '0;
        r_type[i] <= '0;
        r_exc[i]  <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_ir[r_wr_ptr]   <= in_ir;
        r_pc[r_wr_ptr]   <= in_pc;
        r_bd[r_wr_ptr]   <= in_bd;
        r_irn[r_wr_ptr]  <= w_irn;
        r_type[r_wr_ptr] <= w_type;
        r_exc[r_wr_ptr]  <= w_exc;
        r_wr_ptr         <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign out_ir   = r_ir[r_rd_ptr];
  assign out_pc   = r_pc[r_rd_ptr];
  assign out_bd   = r_bd[r_rd_ptr];
  assign out_irn  = r_irn[r_rd_ptr];
  assign out_type = r_type[r_rd_ptr];
  assign out_exc  = r_exc[r_rd_ptr];

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - directed self-checking bench for decode_queue
module tb_decode_queue;

  localparam int DEPTH  = 4;
  localparam int IRN_W  = 6;
  localparam int TYPE_W = 4;

  logic              clk = 1'b0;
  logic              reset, flush, in_valid, in_ready, in_bd;
  logic [31:0]       in_ir, in_pc;
  logic              out_valid, out_ready, out_bd;
  logic [31:0]       out_ir, out_pc;
  logic [IRN_W-1:0]  out_irn;
  logic [TYPE_W-1:0] out_type;
  logic [4:0]        out_exc;
  logic [2:0]        count;

  int pass_cnt  = 0;
  int total_cnt = 0;

  decode_queue #(.DEPTH(DEPTH), .IRN_W(IRN_W), .TYPE_W(TYPE_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc), .in_bd(in_bd),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_pc(out_pc),
    .out_irn(out_irn), .out_type(out_type), .out_bd(out_bd), .out_exc(out_exc),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; out_ready = 0; in_ir = 0; in_pc = 0; in_bd = 0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic push(input logic [31:0] ir, input logic [31:0] pc);
    in_valid = 1; in_ir = ir; in_pc = pc;
    tick();
    in_valid = 0;
  endtask

  task automatic test_reset();
    idle();
    in_valid = 1; in_ir = 32'h00851021; flush = 1; out_ready = 1;
    reset = 1;
    tick();
    reset = 0; idle();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0h exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0h exp=1", in_ready); else pass_cnt++;
    total_cnt++; if (count !== 3'd0) $display("FAIL reset_count got=%0d exp=0", count); else pass_cnt++;
    total_cnt++; if ({out_ir, out_pc} !== 64'h0) $display("FAIL reset_out_words got=%h exp=0", {out_ir, out_pc}); else pass_cnt++;
    total_cnt++; if ({out_irn, out_type, out_exc, out_bd} !== 16'h0) $display("FAIL reset_out_decode got=%h exp=0", {out_irn, out_type, out_exc, out_bd}); else pass_cnt++;
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1; in_bd = 1;
    push(32'h00851021, 32'h00003000);
    in_bd = 0;
    total_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid got=%0h exp=1", out_valid); else pass_cnt++;
    total_cnt++; if (out_irn !== 6'd2) $display("FAIL single_irn got=%0d exp=2", out_irn); else pass_cnt++;
    total_cnt++; if (out_type !== 4'd1) $display("FAIL single_type got=%0d exp=1", out_type); else pass_cnt++;
    total_cnt++; if (out_exc !== 5'd0) $display("FAIL single_exc got=%0d exp=0", out_exc); else pass_cnt++;
    total_cnt++; if (out_bd !== 1'b1 || out_pc !== 32'h3000) $display("FAIL single_bd_pc got=%0h/%h exp=1/00003000", out_bd, out_pc); else pass_cnt++;
    tick();
    total_cnt++; if (out_valid !== 1'b0 || count !== 3'd0) $display("FAIL single_drain got=%0h/%0d exp=0/0", out_valid, count); else pass_cnt++;
    idle();
  endtask

  task automatic test_fill();
    logic [31:0] w [5];
    w = '{32'h8FBF0010, 32'hAFBF0010, 32'h00850018, 32'h1000FFFF, 32'h3C01ABCD};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_ir = w[k]; in_pc = 32'h100 + 32'(4 * k);
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL fill_ready_%0d got=%0h exp=1", k, in_ready); else pass_cnt++;
      tick();
      total_cnt++; if (count !== 3'(k + 1)) $display("FAIL fill_count_%0d got=%0d exp=%0d", k, count, k + 1); else pass_cnt++;
      total_cnt++; if (out_ir !== w[0]) $display("FAIL fill_head_stable_%0d got=%h exp=%h", k, out_ir, w[0]); else pass_cnt++;
    end
    in_ir = w[4]; in_pc = 32'h110;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL fill_full_ready got=%0h exp=0", in_ready); else pass_cnt++;
    out_ready = 1;
    tick();
    in_valid = 0;
    total_cnt++; if (count !== 3'd3) $display("FAIL fill_full_refuse got=%0d exp=3", count); else pass_cnt++;
    for (int k = 1; k < 4; k++) begin
      total_cnt++; if (out_ir !== w[k] || out_pc !== 32'h100 + 32'(4 * k)) $display("FAIL drain_order_%0d got=%h/%h exp=%h", k, out_ir, out_pc, w[k]); else pass_cnt++;
      tick();
    end
    total_cnt++; if (out_valid !== 1'b0 || count !== 3'd0) $display("FAIL drain_empty got=%0h/%0d exp=0/0", out_valid, count); else pass_cnt++;
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    push(32'h3C010000, 32'h200);
    push(32'h3C010001, 32'h204);
    total_cnt++; if (out_irn !== 6'd30 || out_type !== 4'd2) $display("FAIL b2b_lui_decode got=%0d/%0d exp=30/2", out_irn, out_type); else pass_cnt++;
    out_ready = 1;
    for (int c = 0; c < 8; c++) begin
      in_valid = 1; in_ir = 32'h3C010000 | 32'(c + 2); in_pc = 32'h200 + 32'(4 * (c + 2));
      total_cnt++; if (out_ir !== (32'h3C010000 | 32'(c))) $display("FAIL b2b_head_%0d got=%h exp=%h", c, out_ir, 32'h3C010000 | 32'(c)); else pass_cnt++;
      tick();
      total_cnt++; if (count !== 3'd2) $display("FAIL b2b_count_%0d got=%0d exp=2", c, count); else pass_cnt++;
    end
    in_valid = 0;
    total_cnt++; if (out_ir !== 32'h3C010008) $display("FAIL b2b_tail0 got=%h exp=3c010008", out_ir); else pass_cnt++;
    tick();
    total_cnt++; if (out_ir !== 32'h3C010009) $display("FAIL b2b_tail1 got=%h exp=3c010009", out_ir); else pass_cnt++;
    tick();
    total_cnt++; if (count !== 3'd0) $display("FAIL b2b_empty got=%0d exp=0", count); else pass_cnt++;
    idle();
  endtask

  task automatic test_flush();
    do_reset();
    push(32'h00000021, 32'h300);
    push(32'h00000022, 32'h304);
    push(32'h00000023, 32'h308);
    total_cnt++; if (count !== 3'd3) $display("FAIL flush_pre_count got=%0d exp=3", count); else pass_cnt++;
    flush = 1; in_valid = 1; in_ir = 32'hDEADBEEF; in_pc = 32'h30C; out_ready = 1;
    tick();
    idle();
    total_cnt++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) $display("FAIL flush_state got=%0d/%0h/%0h exp=0/0/1", count, out_valid, in_ready); else pass_cnt++;
    push(32'h24420001, 32'h400);
    total_cnt++; if (out_ir !== 32'h24420001 || count !== 3'd1) $display("FAIL flush_after_push got=%h/%0d exp=24420001/1", out_ir, count); else pass_cnt++;
    total_cnt++; if (out_irn !== 6'd26 || out_type !== 4'd2) $display("FAIL flush_addiu_decode got=%0d/%0d exp=26/2", out_irn, out_type); else pass_cnt++;
    idle();
  endtask

  task automatic test_decode();
    logic [31:0] ir  [8];
    logic [5:0]  irn [8];
    logic [3:0]  typ [8];
    ir  = '{32'h03E00008, 32'h0040F809, 32'h1000FFFF, 32'h04410003, 32'h08000000, 32'h0C000000, 32'h8FBF0010, 32'hAFBF0010};
    irn = '{6'd49, 6'd50, 6'd41, 6'd46, 6'd47, 6'd48, 6'd37, 6'd40};
    typ = '{4'd8, 4'd9, 4'd5, 4'd5, 4'd6, 4'd7, 4'd3, 4'd4};
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_ir = ir[i]; in_pc = 32'h500 + 32'(4 * i);
      tick();
      total_cnt++; if (out_irn !== irn[i] || out_type !== typ[i] || out_exc !== 5'd0) $display("FAIL decode_%h got=%0d/%0d/%0d exp=%0d/%0d/0", ir[i], out_irn, out_type, out_exc, irn[i], typ[i]); else pass_cnt++;
    end
    idle();
    tick();
  endtask

  task automatic test_cp0();
    do_reset();
    out_ready = 1;
    push(32'h42000018, 32'h00003000);
`ifdef DECODE_CP0_INSTR_EN
    total_cnt++; if (out_irn !== 6'd51 || out_type !== 4'd10 || out_exc !== 5'd0) $display("FAIL cp0_eret got=%0d/%0d/%0d exp=51/10/0", out_irn, out_type, out_exc); else pass_cnt++;
`else
    total_cnt++; if (out_irn !== 6'd0 || out_type !== 4'd0 || out_exc !== 5'd10) $display("FAIL cp0_eret got=%0d/%0d/%0d exp=0/0/10", out_irn, out_type, out_exc); else pass_cnt++;
`endif
    push(32'h40026000, 32'h00003004);
`ifdef DECODE_CP0_INSTR_EN
    total_cnt++; if (out_irn !== 6'd53 || out_type !== 4'd10 || out_exc !== 5'd0) $display("FAIL cp0_mfc0 got=%0d/%0d/%0d exp=53/10/0", out_irn, out_type, out_exc); else pass_cnt++;
`else
    total_cnt++; if (out_irn !== 6'd0 || out_type !== 4'd0 || out_exc !== 5'd10) $display("FAIL cp0_mfc0 got=%0d/%0d/%0d exp=0/0/10", out_irn, out_type, out_exc); else pass_cnt++;
`endif
    idle();
    tick();
  endtask

  task automatic test_exc();
    do_reset();
    out_ready = 1;
    push(32'h00851021, 32'h00003002);
    total_cnt++; if (out_exc !== 5'd4) $display("FAIL exc_adel got=%0d exp=4", out_exc); else pass_cnt++;
    push(32'hFC000000, 32'h00003004);
    total_cnt++; if (out_exc !== 5'd10 || out_type !== 4'd0 || out_irn !== 6'd0) $display("FAIL exc_ri got=%0d/%0d/%0d exp=10/0/0", out_exc, out_type, out_irn); else pass_cnt++;
    push(32'hFC000000, 32'h00003001);
    total_cnt++; if (out_exc !== 5'd4) $display("FAIL exc_adel_over_ri got=%0d exp=4", out_exc); else pass_cnt++;
    idle();
    tick();
  endtask

  task automatic test_reset_midstream();
    do_reset();
    push(32'h00851021, 32'h600);
    push(32'h24420001, 32'h604);
    reset = 1; flush = 1; in_valid = 1; in_ir = 32'h3C01FFFF; out_ready = 1;
    tick();
    reset = 0; idle();
    total_cnt++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL midreset_state got=%0d/%0h exp=0/0", count, out_valid); else pass_cnt++;
    total_cnt++; if (out_ir !== 32'h0 || out_irn !== 6'd0) $display("FAIL midreset_entries got=%h/%0d exp=0/0", out_ir, out_irn); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_flush();
    test_decode();
    test_cp0();
    test_exc();
    test_reset_midstream();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/decode_queue.md
DECODE_QUEUE -- requirements
Module: decode_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-002 Parameter IRN_W, default 6, width of the instruction-number field.
REQ-003 Parameter TYPE_W, default 4, width of the instruction-class field.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 reset  input  1  reset is synchronous and active-high.
REQ-006 flush  input  1  discard all entries (branch redirect / exception entry).
REQ-007 in_valid  input  1  upstream offers an instruction.
REQ-008 in_ready  output  1  queue accepts this cycle.
REQ-009 in_ir  input  32  raw instruction word.
REQ-010 in_pc  input  32  instruction address.
REQ-011 in_bd  input  1  instruction sits in a branch delay slot.
REQ-012 out_valid  output  1  head entry present.
REQ-013 out_ready  input  1  downstream consumes head.
REQ-014 out_ir, out_pc  output  32 each  head raw word and address.
REQ-015 out_irn  output  IRN_W  decoded instruction number; 0 = unrecognised.
REQ-016 out_type  output  TYPE_W  instruction class.
REQ-017 out_bd  output  1  head delay-slot flag.
REQ-018 out_exc  output  5  exception code: 0 none, 4 AdEL, 10 RI.
REQ-019 count  output  clog2(DEPTH)+1  current occupancy.

Function
REQ-020 Push occurs when in_valid && in_ready && !flush; pop occurs when out_valid && out_ready && !flush.
REQ-021 in_ready SHALL equal (count != DEPTH), independent of out_ready; a full queue refuses a push even when a pop happens that cycle.
REQ-022 out_valid SHALL equal (count != 0); out_* SHALL be driven from the head entry's registers.
REQ-023 Decode (irn, type, exc) SHALL be computed combinationally from in_ir/in_pc at push time and stored with the entry; no decode logic on the output path.
REQ-024 Latency: an entry pushed at edge N SHALL be visible at out_* after edge N (one cycle), including when the queue was empty.
REQ-025 Simultaneous push and pop SHALL leave count unchanged and preserve FIFO order.
REQ-026 Read/write pointers SHALL wrap modulo DEPTH.
REQ-027 While out_valid && !out_ready, all out_* SHALL hold stable.
REQ-028 Instruction decode SHALL cover the full MIPS-C set: calr (add..mflo incl. mult/div/mthi/mtlo/mfhi/mflo), cali, load, store, branch (beq,bne,blez,bgtz,bltz,bgez), j, jal, jr, jalr.
REQ-029 Class codes: 0 none, 1 calr, 2 cali, 3 ld, 4 st, 5 branch, 6 j, 7 jal, 8 jr, 9 jalr, 10 cp0.
REQ-030 in_pc[1:0] != 0 SHALL give exc 4 (AdEL), overriding RI; otherwise irn==0 SHALL give exc 10 (RI) with type 0; otherwise exc 0.
REQ-031 flush SHALL, at the next edge, zero count and both pointers; flush dominates a same-cycle push and pop (both dropped).

Reset
REQ-032 On reset at an edge: count 0, pointers 0, all stored entries 0, hence out_valid 0, all out_* 0, in_ready 1.
REQ-033 reset dominates flush, push and pop in the same cycle; reset mid-stream discards all entries.

Configuration
REQ-034 Macro DECODE_CP0_INSTR_EN defined: eret (op 010000, func 011000), mtc0 (op 010000, rs 00100), mfc0 (op 010000, rs 00000) SHALL decode to their numbers with type 10.
REQ-035 Macro undefined: those three encodings SHALL decode as irn 0, type 0, exc 10.

Structure
REQ-036 Instruction-number constants, class codes, exception codes and opcode/func field ranges SHALL live in the shared package/header used by the pipeline.
REQ-037 The pure combinational decode SHALL be one sub-module, instr_classifier (in_ir, in_pc -> irn, type, exc); decode_queue holds storage, pointers and handshake.

Verification
REQ-038 Push 0x00851021 (addu) at pc 0x00003000, out_ready=1 -> next cycle out_valid=1, out_irn=addu, out_type=1, out_exc=0.
REQ-039 Push 5 words back-to-back with out_ready=0 -> 4 accepted, count=4, in_ready=0 on the 5th; then pop drains them in order.
REQ-040 count=2, simultaneous push and pop for 8 cycles -> count stays 2, output order matches input order across pointer wrap.
REQ-041 count=3, flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, pushed word absent.
REQ-042 Push 0x42000018 (eret): with DECODE_CP0_INSTR_EN -> type 10, exc 0; without -> irn 0, exc 10.
REQ-043 Push 0x00851021 at pc 0x00003002 -> out_exc=4; push 0xFC000000 at pc 0x00003004 -> out_exc=10, out_type=0.
